// File: rtl/bin2bcd_32_if.sv
// Request/response bundle for bin2bcd_32: binary request in, packed BCD result out.
// The requester drives the master modport and the converter implements the slave modport.
interface bin2bcd_32_if #(
    parameter int DATA_W = 27
);
    logic [DATA_W-1:0] bin_i;
    logic              valid_i;
    logic              ready_o;
    logic [31:0]       data_o;
    logic              ovf_o;
    logic              done_o;

    modport master (
        output bin_i,
        output valid_i,
        input  ready_o,
        input  data_o,
        input  ovf_o,
        input  done_o
    );

    modport slave (
        input  bin_i,
        input  valid_i,
        output ready_o,
        output data_o,
        output ovf_o,
        output done_o
    );
endinterface

// File: rtl/bin2bcd_32.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Optional feature macro BIN2BCD_SAT_EN: an overflowing result reads as 32'h9999_9999.
module bin2bcd_32 #(
    parameter int DATA_W = 27
) (
    input  logic         clk,
    input  logic         rst_i,
    bin2bcd_32_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            r_state;
    logic [39:0]       r_acc;
    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_data;
    logic              r_ovf;
    logic              r_done;
    logic              r_ready;

    logic [35:0]       w_adj;
    logic              w_ovf;
    logic [31:0]       w_data;

    // Add-3 correction for digits 0..8. Digit 9 never exceeds 4 for a 32-bit input,
    // so it needs no correction and only its low three bits survive the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_digit
            assign w_adj[gi*4 +: 4] = (r_acc[gi*4 +: 4] >= 4'd5) ?
                                      (r_acc[gi*4 +: 4] + 4'd3) :
                                      r_acc[gi*4 +: 4];
        end
    endgenerate

    assign w_ovf = |r_acc[39:32];

`ifdef BIN2BCD_SAT_EN
    assign w_data = w_ovf ? 32'h9999_9999 : r_acc[31:0];
`else
    assign w_data = r_acc[31:0];
`endif

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.valid_i) begin
                        r_shreg <= bus.bin_i;
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(DATA_W);
                        r_ready <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc   <= {r_acc[38:36], w_adj, r_shreg[DATA_W-1]};
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Outputs change only here, keeping them steady for the display mux.
                    r_data  <= w_data;
                    r_ovf   <= w_ovf;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o = r_ready;
    assign bus.data_o  = r_data;
    assign bus.ovf_o   = r_ovf;
    assign bus.done_o  = r_done;
endmodule

// File: tb/tb_bin2bcd_32.sv
// Scoreboard bench for bin2bcd_32: directed requests push expected results,
// a negedge monitor pops and checks them whenever done_o is seen.
module tb_bin2bcd_32;
    localparam int DATA_W  = 27;
    localparam int LATENCY = 29;  // negedge-sample count from request setup to done_o

    logic clk   = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    bin2bcd_32_if #(.DATA_W(DATA_W)) bus ();

    bin2bcd_32 #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        int unsigned bin;
        logic [31:0] data;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst_i && bus.done_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: actual data=%h required no done_o (cycle %0d)",
                         bus.data_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("xfer bin=%0d data=%h ovf=%0b exp_data=%h exp_ovf=%0b cycle=%0d",
                         e.bin, bus.data_o, bus.ovf_o, e.data, e.ovf, cyc);
                check("data", bus.data_o, e.data);
                check("ovf", {31'd0, bus.ovf_o}, {31'd0, e.ovf});
                check("latency", cyc, e.cyc);
                check("ready_with_done", {31'd0, bus.ready_o}, 32'd1);
            end
        end
    end

    task automatic issue(input int unsigned v, input logic [31:0] d, input logic o);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (bus.ready_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready_o !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: actual ready=%b required 1", bus.ready_o);
        end
        bus.bin_i   = DATA_W'(v);
        bus.valid_i = 1'b1;
        e.bin = v; e.data = d; e.ovf = o; e.cyc = cyc + LATENCY;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   n;
        bus.valid_i = 1'b0;
        bus.bin_i   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data", bus.data_o, 32'h0);
        check("rst_ovf", {31'd0, bus.ovf_o}, 32'd0);
        check("rst_done", {31'd0, bus.done_o}, 32'd0);
        check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
        rst_i = 1'b0;

        // Directed conversions
        issue(12_345_678, 32'h1234_5678, 1'b0);
        issue(0, 32'h0000_0000, 1'b0);
        issue(99_999_999, 32'h9999_9999, 1'b0);
`ifdef BIN2BCD_SAT_EN
        issue(123_456_789, 32'h9999_9999, 1'b1);
        issue(134_217_727, 32'h9999_9999, 1'b1);
        issue(100_000_000, 32'h9999_9999, 1'b1);
`else
        issue(123_456_789, 32'h2345_6789, 1'b1);
        issue(134_217_727, 32'h3421_7727, 1'b1);
        issue(100_000_000, 32'h0000_0000, 1'b1);
`endif
        issue(1, 32'h0000_0001, 1'b0);
        issue(10, 32'h0000_0010, 1'b0);

        // valid_i held high with bin_i toggling; back-to-back accept in the done_o cycle
        @(negedge clk);
        n = 0;
        while (bus.ready_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.bin_i   = DATA_W'(5);
        bus.valid_i = 1'b1;
        e.bin = 5; e.data = 32'h0000_0005; e.ovf = 1'b0; e.cyc = cyc + LATENCY;
        sb.push_back(e);
        for (int k = 1; k < LATENCY; k++) begin
            @(negedge clk);
            bus.bin_i = DATA_W'(k * 7_777_777);
            check("busy_ready_low", {31'd0, bus.ready_o}, 32'd0);
        end
        @(negedge clk);
        bus.bin_i = DATA_W'(87_654_321);
        e.bin = 87_654_321; e.data = 32'h8765_4321; e.ovf = 1'b0; e.cyc = cyc + LATENCY;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.valid_i = 1'b0;

        // Reset 10 cycles into a conversion aborts it
        issue(55_555, 32'h0005_5555, 1'b0);
        repeat (10) @(negedge clk);
        rst_i = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("abort_data", bus.data_o, 32'h0);
        check("abort_ready", {31'd0, bus.ready_o}, 32'd1);
        check("abort_done", {31'd0, bus.done_o}, 32'd0);
        repeat (40) @(negedge clk);
        issue(42, 32'h0000_0042, 1'b0);

        // Drain outstanding expectations
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: actual pending=%0d required 0", sb.size());
        end
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
